// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the PE stream driver and its result FIFO:
//   - default datapath widths for the PE interface
//   - command opcode encodings carried on cmd_op
//   - driver state enum (whether a weight has ever been loaded)
// -----------------------------------------------------------------------------
package pe_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_PSUM_W = 32;

  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_MAC  = 1'b1;

  typedef enum logic {
    UNLOADED = 1'b0,
    LOADED   = 1'b1
  } drv_state_e;

endpackage : pe_pkg

// File: rtl/pe_result_fifo.sv
// -----------------------------------------------------------------------------
// pe_result_fifo
// Synchronous FIFO holding captured MAC results until the consumer takes them.
// The head entry is presented combinationally and reads as zero while empty.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   push         write push_data this edge (ignored when full and not popping)
//   push_data    entry to write
//   pop          remove head this edge (ignored when empty)
//   head_data    current head entry, zero when empty
//   full, empty  occupancy flags
//   count        number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module pe_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign w_do_pop  = pop && !empty;
  // A full FIFO may still accept a write when the head leaves on the same edge.
  assign w_do_push = push && (!full || w_do_pop);

  // NOTE: the storage array has no reset; empty/head gating makes stale
  // contents unobservable, so resetting it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointer width equals log2(DEPTH), so increments wrap modulo DEPTH.
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_data = empty ? '0 : r_mem[r_rd_ptr];

endmodule : pe_result_fifo

// File: rtl/pe_stream_driver.sv
// -----------------------------------------------------------------------------
// pe_stream_driver
// Drives LOAD / MAC commands into one weight-stationary PE, one per cycle, and
// returns MAC results in command order through a result FIFO.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_op                   OP_LOAD (weight) or OP_MAC (activation + psum)
//   cmd_data, cmd_psum       weight/activation and partial sum
//   en_store, pe_in, psum_in registered drive into the PE
//   psum_out                 PE result, valid PE_LAT cycles after the PE samples
//   res_valid/res_ready      result handshake, res_data is the FIFO head
//   err_no_weight            sticky: a MAC was accepted before any LOAD
// -----------------------------------------------------------------------------
module pe_stream_driver
  import pe_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int PSUM_W     = DEF_PSUM_W,
  parameter int PE_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [PSUM_W-1:0] cmd_psum,
  output logic              en_store,
  output logic [DATA_W-1:0] pe_in,
  output logic [PSUM_W-1:0] psum_in,
  input  logic [PSUM_W-1:0] psum_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [PSUM_W-1:0] res_data,
  output logic              err_no_weight
);

  localparam int TAG_N = PE_LAT + 1;
  localparam int IW    = $clog2(TAG_N + 1);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  drv_state_e        r_state;
  drv_state_e        w_state_next;
  logic              w_err_set;
  logic              r_err;

  logic              r_en_store;
  logic [DATA_W-1:0] r_pe_in;
  logic [PSUM_W-1:0] r_psum_in;

  // One tag per cycle between MAC acceptance and psum_out being valid.
  logic [TAG_N-1:0]  r_tag;
  logic [IW-1:0]     w_inflight;

  logic              w_accept;
  logic              w_mac_acc;
  logic              w_load_acc;
  logic              w_capture;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CW-1:0]     w_fifo_count;

  assign w_accept   = cmd_valid && cmd_ready;
  assign w_mac_acc  = w_accept && (cmd_op == OP_MAC);
  assign w_load_acc = w_accept && (cmd_op == OP_LOAD);
  assign w_capture  = r_tag[PE_LAT];

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < TAG_N; i++) begin
      w_inflight = w_inflight + IW'(r_tag[i]);
    end
  end

  // Counting in-flight MACs as already occupying a slot means a captured
  // result always finds room, so psum_out never needs a stall path.
  // full already implies the sum check fails; it just makes that explicit.
  assign cmd_ready = !w_fifo_full &&
                     ((int'(w_fifo_count) + int'(w_inflight)) < FIFO_DEPTH);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= UNLOADED;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_err   <= r_err | w_err_set;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_err_set    = 1'b0;
    case (r_state)
      UNLOADED: begin
        if (w_load_acc) w_state_next = LOADED;
        // The MAC is still issued; the flag only records the misuse.
        if (w_mac_acc)  w_err_set    = 1'b1;
      end
      LOADED:  w_state_next = LOADED;
      default: w_state_next = UNLOADED;
    endcase
  end

  // ------------------------------------------------ PE drive and tag pipe
  // Idle cycles drive an all-zero NOP so the PE never sees stale operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_store <= 1'b0;
      r_pe_in    <= '0;
      r_psum_in  <= '0;
      r_tag      <= '0;
    end else begin
      r_en_store <= w_load_acc;
      r_pe_in    <= w_accept  ? cmd_data : '0;
      r_psum_in  <= w_mac_acc ? cmd_psum : '0;
      r_tag[0]   <= w_mac_acc;
      for (int i = 1; i < TAG_N; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // ----------------------------------------------------------- results
  assign w_pop = res_valid && res_ready;

  pe_result_fifo #(
    .WIDTH (PSUM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_capture),
    .push_data (psum_out),
    .pop       (w_pop),
    .head_data (res_data),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  assign res_valid     = !w_fifo_empty;
  assign en_store      = r_en_store;
  assign pe_in         = r_pe_in;
  assign psum_in       = r_psum_in;
  assign err_no_weight = r_err;

endmodule : pe_stream_driver

// File: tb/tb_pe_stream_driver.sv
// -----------------------------------------------------------------------------
// tb_pe_stream_driver
// Bench for pe_stream_driver with a behavioural weight-stationary PE (latency
// 1) closing the loop from en_store/pe_in/psum_in back to psum_out. Expected
// MAC results are pushed to a scoreboard queue on command acceptance and popped
// whenever the consumer takes a result.
// -----------------------------------------------------------------------------
module tb_pe_stream_driver;
  import pe_pkg::*;

  localparam int PE_LAT     = 1;
  localparam int FIFO_DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_op;
  logic signed [7:0]  cmd_data;
  logic signed [31:0] cmd_psum;
  logic               en_store;
  logic signed [7:0]  pe_in;
  logic signed [31:0] psum_in;
  logic signed [31:0] psum_out;
  logic               res_valid;
  logic               res_ready;
  logic signed [31:0] res_data;
  logic               err_no_weight;

  pe_stream_driver #(
    .DATA_W     (8),
    .PSUM_W     (32),
    .PE_LAT     (PE_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_data      (cmd_data),
    .cmd_psum      (cmd_psum),
    .en_store      (en_store),
    .pe_in         (pe_in),
    .psum_in       (psum_in),
    .psum_out      (psum_out),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .err_no_weight (err_no_weight)
  );

  always #5 clk = ~clk;

  // Behavioural PE: stores the weight on en_store, otherwise psum + in*weight.
  logic signed [7:0] pe_weight;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_weight <= '0;
      psum_out  <= '0;
    end else begin
      if (en_store) pe_weight <= pe_in;
      psum_out <= psum_in + pe_in * pe_weight;
    end
  end

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int n_cmp = 0;
  int n_err = 0;
  logic signed [31:0] sb_q[$];
  int first_rise = -1;
  int acc_cycle  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at cycle %0d",
               name, $signed(act), act, $signed(exp), exp, cycle);
    end
  endtask

  // Monitor: scoreboard compare on every taken result, hold check on stalls.
  logic               stall_prev = 1'b0;
  logic signed [31:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("res_hold_valid", res_valid, 1);
        check("res_hold_data", res_data, held);
      end
      if (res_valid && first_rise < 0) first_rise = cycle;
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) check("unexpected_result", 1, 0);
        else check("res_data", res_data, sb_q.pop_front());
      end
      stall_prev = res_valid && !res_ready;
      held       = res_data;
    end
  end

  // Drive one command; returns #1 after the accepting edge.
  task automatic send(input logic op, input logic signed [7:0] d,
                      input logic signed [31:0] p, input logic signed [31:0] exp);
    int waited = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_psum = p;
    @(negedge clk);
    while (!cmd_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!cmd_ready) begin
      check("send_timeout", 0, 1);
      cmd_valid = 1'b0;
    end else begin
      if (op == OP_MAC) sb_q.push_back(exp);
      @(posedge clk);
      #1;
      acc_cycle = cycle;
    end
  endtask

  task automatic idle();
    cmd_valid = 1'b0; cmd_op = OP_LOAD; cmd_data = '0; cmd_psum = '0;
  endtask

  task automatic drain();
    int waited = 0;
    while (sb_q.size() != 0 && waited < 50) begin
      waited++;
      @(posedge clk);
    end
    check("drain_left", sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic               op;
    logic signed [7:0]  data;
    logic signed [31:0] psum;
    logic signed [31:0] exp;
  } vec_t;

  vec_t tbl [8];
  int   t_mac;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Scenario 1: weight 94.  87*94+4265, -78*94+4265, 78*94-38426.
    tbl[0] = '{OP_LOAD,   94,       0,       0};
    tbl[1] = '{OP_MAC,    87,    4265,   12443};
    tbl[2] = '{OP_MAC,   -78,    4265,   -3067};
    tbl[3] = '{OP_MAC,    78,  -38426,  -31094};
    // Scenario 2: MAC before the LOAD still sees 94 (10*94+100).
    tbl[4] = '{OP_MAC,    10,     100,    1040};
    tbl[5] = '{OP_LOAD,  -49,       0,       0};
    tbl[6] = '{OP_MAC,   -32,    4265,    5833};
    tbl[7] = '{OP_MAC,  -127, -453276, -447053};

    idle();
    res_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_en_store", en_store, 0);
    check("rst_pe_in", pe_in, 0);
    check("rst_psum_in", psum_in, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_err", err_no_weight, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Scenario 5: MAC with no weight ever loaded -> result is psum, flag set.
    send(OP_MAC, 5, 4265, 4265);
    idle();
    drain();
    check("err_set", err_no_weight, 1);

    // Scenario 4: idle drives NOP; a lone LOAD gives no result.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nop_drive", {en_store, pe_in, psum_in}, 0);
    end
    @(posedge clk); #1;
    send(OP_LOAD, 94, 0, 0);
    check("load_en_store", en_store, 1);
    check("load_pe_in", pe_in, 94);
    check("load_psum_in", psum_in, 0);
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("load_no_result", res_valid, 0);
    end
    check("err_sticky", err_no_weight, 1);
    @(posedge clk); #1;

    // Scenario 1: back-to-back stream with first-result latency.
    first_rise = -1;
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].op, tbl[i].data, tbl[i].psum, tbl[i].exp);
      if (i == 1) t_mac = acc_cycle;
    end
    idle();
    drain();
    check("first_latency", first_rise - t_mac, PE_LAT + 1);

    // Scenario 2: weight change ordered strictly by command order.
    for (int i = 4; i < 8; i++) send(tbl[i].op, tbl[i].data, tbl[i].psum, tbl[i].exp);
    idle();
    drain();

    // Scenario 3: backpressure with weight -49; MAC i = (i+1, 1000*i).
    begin
      int idx = 0;
      res_ready = 1'b0;
      cmd_valid = 1'b1; cmd_op = OP_MAC;
      cmd_data = 8'(idx + 1); cmd_psum = 1000 * idx;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (cmd_ready) sb_q.push_back(1000 * idx + (idx + 1) * (-49));
        @(posedge clk); #1;
        if (sb_q.size() > idx) begin
          idx++;
          cmd_data = 8'(idx + 1); cmd_psum = 1000 * idx;
        end
      end
      check("bp_accepts", idx, FIFO_DEPTH);
      check("bp_ready_low", cmd_ready, 0);
      res_ready = 1'b1;
      @(negedge clk);
      check("ready_before_pop", cmd_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("ready_after_pop", cmd_ready, 1);
      sb_q.push_back(1000 * idx + (idx + 1) * (-49));
      @(posedge clk); #1;
      idx++;
      send(OP_MAC, 8'(idx + 1), 1000 * idx, 1000 * idx + (idx + 1) * (-49));
      idle();
      drain();
    end

    // Scenario 6: async reset with 2 buffered and 1 in flight.
    res_ready = 1'b0;
    send(OP_MAC, 1, 1, -48);
    send(OP_MAC, 2, 2, -96);
    send(OP_MAC, 3, 3, -144);
    idle();
    @(posedge clk); #2;
    check("pre_rst_valid", res_valid, 1);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    check("arst_en_store", en_store, 0);
    check("arst_pe_in", pe_in, 0);
    check("arst_psum_in", psum_in, 0);
    check("arst_res_valid", res_valid, 0);
    check("arst_res_data", res_data, 0);
    check("arst_err", err_no_weight, 0);
    check("arst_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_result", res_valid, 0);
    end
    @(posedge clk); #1;
    first_rise = -1;
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].op, tbl[i].data, tbl[i].psum, tbl[i].exp);
      if (i == 1) t_mac = acc_cycle;
    end
    idle();
    drain();
    check("post_rst_latency", first_rise - t_mac, PE_LAT + 1);
    check("post_rst_err", err_no_weight, 0);
    check("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pe_stream_driver
